stream_demux: RTL and testbench



---
 rtl/stream_demux_pkg.sv | 28 ++
 rtl/stream_demux_out_stage.sv | 83 ++++++++
 rtl/stream_demux.sv | 113 +++++++++++
 tb/tb_stream_demux.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared definitions for the 1:2 stream demultiplexer:
//   - default data / counter widths
//   - channel encodings used by in_sel and the round-robin pointer
//   - helper that advances the round-robin pointer
// -----------------------------------------------------------------------------
package stream_demux_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  // Channel encodings: the select input and the round-robin pointer share them.
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Next round-robin pointer: flips to the other channel only when advancing.
  function automatic logic rr_next(input logic ptr, input logic adv);
    logic nxt;
    if (adv) begin
      nxt = ~ptr;
    end else begin
      nxt = ptr;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stream_demux_out_stage.sv
// -----------------------------------------------------------------------------
// out_stage
// One output channel of the demultiplexer: a single-word register with a
// valid flag, the "can accept a new word" indication, and a counter of
// completed output handshakes.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   load     in   write d into the stage this cycle (only when can_load=1)
//   d        in   word to store
//   data     out  held word (keeps last value after it drains)
//   valid    out  stage holds a word
//   ready    in   consumer accepts the held word
//   can_load out  stage is empty or is draining this cycle
//   cnt_clr  in   synchronous clear of the transfer counter
//   cnt      out  completed transfers, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module out_stage
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              can_load,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_fire;

  // Output handshake and load-permission decode.
  always_comb begin
    w_fire   = r_valid & ready;
    // A draining stage may be refilled in the same cycle (full throughput).
    can_load = ~r_valid | ready;
  end

  // Word register and valid flag; a load wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= {DATA_W{1'b0}};
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= d;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      r_data  <= r_data;
      r_valid <= 1'b0;
    end else begin
      r_data  <= r_data;
      r_valid <= r_valid;
    end
  end

  // Transfer counter; clear has priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_fire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign cnt   = r_cnt;

endmodule

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
// Registered 1:2 stream demultiplexer. Each accepted input word is steered to
// output A or B, chosen either by in_sel or by a round-robin pointer. Each
// output owns a one-word register stage and a transfer counter.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_data/in_valid    input stream word and its valid
//   in_ready            combinational: the targeted stage can take a word
//   in_sel              target when rr_mode=0 (0=A, 1=B)
//   rr_mode             1 = alternate targets on every accepted word
//   cnt_clr             synchronous clear of both transfer counters
//   a_*/b_*             output streams (data, valid, ready)
//   cnt_a/cnt_b         completed output transfers per channel
// -----------------------------------------------------------------------------
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic              rr_mode,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] a_data,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  logic r_rr_ptr;
  logic w_tgt;
  logic w_can_a;
  logic w_can_b;
  logic w_accept;
  logic w_load_a;
  logic w_load_b;

  // Target selection and input-side handshake. in_ready follows the target's
  // can-load so that switching to a free channel unblocks in the same cycle.
  always_comb begin
    w_tgt = CH_A;
    if (rr_mode) begin
      w_tgt = r_rr_ptr;
    end else begin
      w_tgt = in_sel;
    end

    in_ready = 1'b0;
    case (w_tgt)
      CH_A:    in_ready = w_can_a;
      CH_B:    in_ready = w_can_b;
      default: in_ready = 1'b0;
    endcase

    w_accept = in_valid & in_ready;
    w_load_a = w_accept & (w_tgt == CH_A);
    w_load_b = w_accept & (w_tgt == CH_B);
  end

  // Round-robin pointer: advances only on an accepted word in round-robin
  // mode, so leaving and re-entering the mode resumes where it stopped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= CH_A;
    end else begin
      r_rr_ptr <= rr_next(r_rr_ptr, w_accept & rr_mode);
    end
  end

  out_stage #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_stage_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load_a),
    .d        (in_data),
    .data     (a_data),
    .valid    (a_valid),
    .ready    (a_ready),
    .can_load (w_can_a),
    .cnt_clr  (cnt_clr),
    .cnt      (cnt_a)
  );

  out_stage #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_stage_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load_b),
    .d        (in_data),
    .data     (b_data),
    .valid    (b_valid),
    .ready    (b_ready),
    .can_load (w_can_b),
    .cnt_clr  (cnt_clr),
    .cnt      (cnt_b)
  );

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
// Self-checking bench for stream_demux: a directed vector table, a counter
// wrap sequence, and randomized traffic compared against a behavioural model
// with per-channel word queues.
// -----------------------------------------------------------------------------
module tb_stream_demux;

  localparam int TB_DATA_W = 32;
  localparam int TB_CNT_W  = 8;
  localparam int CNT_MOD   = 1 << TB_CNT_W;

  logic                 clk;
  logic                 rst_n;
  logic [TB_DATA_W-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sel;
  logic                 rr_mode;
  logic                 cnt_clr;
  logic [TB_DATA_W-1:0] a_data;
  logic                 a_valid;
  logic                 a_ready;
  logic [TB_DATA_W-1:0] b_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [TB_CNT_W-1:0]  cnt_a;
  logic [TB_CNT_W-1:0]  cnt_b;

  stream_demux #(
    .DATA_W (TB_DATA_W),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .rr_mode  (rr_mode),
    .cnt_clr  (cnt_clr),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each channel: does it hold a word, what word it shows, how many transfers.
  logic                 m_v[2];
  logic [TB_DATA_W-1:0] m_d[2];
  int                   m_cnt[2];
  logic                 m_ptr;          // 0 -> next round-robin word goes to A
  logic [TB_DATA_W-1:0] sb_q[2][$];     // accepted words not yet handed over
  logic                 ir_sampled;
  logic                 m_ir;

  function automatic logic model_ready();
    int t;
    logic rdy[2];
    rdy[0] = a_ready;
    rdy[1] = b_ready;
    t = rr_mode ? int'(m_ptr) : int'(in_sel);
    return !m_v[t] || rdy[t];
  endfunction

  task automatic model_edge();
    logic rdy[2];
    int t;
    logic acc;
    rdy[0] = a_ready;
    rdy[1] = b_ready;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_v[c] = 1'b0;
        m_d[c] = '0;
        m_cnt[c] = 0;
        sb_q[c].delete();
      end
      m_ptr = 1'b0;
    end else begin
      t = rr_mode ? int'(m_ptr) : int'(in_sel);
      acc = in_valid && (!m_v[t] || rdy[t]);
      for (int c = 0; c < 2; c++) begin
        if (m_v[c] && rdy[c]) begin
          m_v[c] = 1'b0;
          m_cnt[c] = (m_cnt[c] + 1) % CNT_MOD;
        end
        if (cnt_clr) m_cnt[c] = 0;
      end
      if (acc) begin
        m_v[t] = 1'b1;
        m_d[t] = in_data;
        sb_q[t].push_back(in_data);
        if (rr_mode) m_ptr = ~m_ptr;
      end
    end
  endtask

  // One clock: sample in_ready mid-cycle, check handovers, advance the model.
  task automatic step();
    logic [TB_DATA_W-1:0] exp_w;
    #4;
    ir_sampled = in_ready;
    m_ir = model_ready();
    if (rst_n === 1'b1 && a_valid === 1'b1 && a_ready === 1'b1) begin
      if (sb_q[0].size() == 0) chk("sb_a_empty", 64'd1, 64'd0);
      else begin
        exp_w = sb_q[0].pop_front();
        chk("sb_a_word", 64'(a_data), 64'(exp_w));
      end
    end
    if (rst_n === 1'b1 && b_valid === 1'b1 && b_ready === 1'b1) begin
      if (sb_q[1].size() == 0) chk("sb_b_empty", 64'd1, 64'd0);
      else begin
        exp_w = sb_q[1].pop_front();
        chk("sb_b_word", 64'(b_data), 64'(exp_w));
      end
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic                 rst_n, v, sel, rr, clr, ar, br;
    logic [TB_DATA_W-1:0] d;
    logic                 chk_ir, eir, eav;
    logic [TB_DATA_W-1:0] ead;
    logic                 ebv;
    logic [TB_DATA_W-1:0] ebd;
    int                   eca, ecb;
  } vec_t;

  vec_t tq[$];

  task automatic add(input logic r, v, s, rr, clr, ar, br, input logic [31:0] d,
                     input logic ci, eir, eav, input logic [31:0] ead,
                     input logic ebv, input logic [31:0] ebd, input int eca, ecb);
    vec_t x;
    x.rst_n = r; x.v = v; x.sel = s; x.rr = rr; x.clr = clr; x.ar = ar; x.br = br;
    x.d = d; x.chk_ir = ci; x.eir = eir; x.eav = eav; x.ead = ead;
    x.ebv = ebv; x.ebd = ebd; x.eca = eca; x.ecb = ecb;
    tq.push_back(x);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_in_ready"}, 64'(ir_sampled), 64'(m_ir));
    chk({tag, "_a_valid"}, 64'(a_valid), 64'(m_v[0]));
    chk({tag, "_b_valid"}, 64'(b_valid), 64'(m_v[1]));
    chk({tag, "_a_data"}, 64'(a_data), 64'(m_d[0]));
    chk({tag, "_b_data"}, 64'(b_data), 64'(m_d[1]));
    chk({tag, "_cnt_a"}, 64'(cnt_a), 64'(m_cnt[0]));
    chk({tag, "_cnt_b"}, 64'(cnt_b), 64'(m_cnt[1]));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; rr_mode = 1'b0; cnt_clr = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1; in_data = '0;
    m_ptr = 1'b0;
    for (int c = 0; c < 2; c++) begin m_v[c] = 1'b0; m_d[c] = '0; m_cnt[c] = 0; end

    //    rst v  sel rr clr ar br data            ci eir av ad            bv bd            ca cb
    add(0, 1, 0, 0, 0, 1, 1, 32'hDEADBEEF,  0, 0, 0, 32'h0,        0, 32'h0,        0, 0);
    add(0, 1, 0, 0, 0, 1, 1, 32'hDEADBEEF,  1, 1, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 0, 0, 0, 0, 1, 1, 32'h0,         1, 1, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 1, 0, 0, 0, 1, 1, 32'hF0F0F0F0,  1, 1, 1, 32'hF0F0F0F0, 0, 32'h0,        0, 0);
    add(1, 1, 1, 0, 0, 1, 1, 32'h0F0F0F0F,  1, 1, 0, 32'hF0F0F0F0, 1, 32'h0F0F0F0F, 1, 0);
    add(1, 0, 1, 0, 0, 1, 1, 32'h0,         1, 1, 0, 32'hF0F0F0F0, 0, 32'h0F0F0F0F, 1, 1);
    // backpressure on A
    add(1, 1, 0, 0, 0, 0, 1, 32'h11111111,  1, 1, 1, 32'h11111111, 0, 32'h0F0F0F0F, 1, 1);
    add(1, 1, 0, 0, 0, 0, 1, 32'h33333333,  1, 0, 1, 32'h11111111, 0, 32'h0F0F0F0F, 1, 1);
    add(1, 1, 1, 0, 0, 0, 1, 32'h22222222,  1, 1, 1, 32'h11111111, 1, 32'h22222222, 1, 1);
    add(1, 0, 0, 0, 0, 1, 1, 32'h0,         1, 1, 0, 32'h11111111, 0, 32'h22222222, 2, 2);
    // round-robin 1..4 with in_sel=1 ignored
    add(1, 1, 1, 1, 0, 1, 1, 32'h1,         1, 1, 1, 32'h1,        0, 32'h22222222, 2, 2);
    add(1, 1, 1, 1, 0, 1, 1, 32'h2,         1, 1, 0, 32'h1,        1, 32'h2,        3, 2);
    add(1, 1, 1, 1, 0, 1, 1, 32'h3,         1, 1, 1, 32'h3,        0, 32'h2,        3, 3);
    add(1, 1, 1, 1, 0, 1, 1, 32'h4,         1, 1, 0, 32'h3,        1, 32'h4,        4, 3);
    // pointer held while rr_mode=0, resumes at A
    add(1, 1, 1, 0, 0, 1, 1, 32'h5,         1, 1, 0, 32'h3,        1, 32'h5,        4, 4);
    add(1, 1, 1, 1, 0, 1, 1, 32'h6,         1, 1, 1, 32'h6,        0, 32'h5,        4, 5);
    // clear wins over a same-cycle A handshake
    add(1, 0, 0, 0, 1, 1, 1, 32'h0,         1, 1, 0, 32'h6,        0, 32'h5,        0, 0);
    // mid-stream reset with A stalled
    add(1, 1, 0, 0, 0, 0, 1, 32'h77,        1, 1, 1, 32'h77,       0, 32'h5,        0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 32'h88,        1, 0, 0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 1, 1, 1, 0, 1, 1, 32'h99,        1, 1, 1, 32'h99,       0, 32'h0,        0, 0);
    add(1, 0, 1, 1, 0, 1, 1, 32'h0,         1, 1, 0, 32'h99,       0, 32'h0,        1, 0);

    foreach (tq[i]) begin
      rst_n = tq[i].rst_n; in_valid = tq[i].v; in_sel = tq[i].sel; rr_mode = tq[i].rr;
      cnt_clr = tq[i].clr; a_ready = tq[i].ar; b_ready = tq[i].br; in_data = tq[i].d;
      step();
      if (tq[i].chk_ir) chk($sformatf("v%0d_in_ready", i), 64'(ir_sampled), 64'(tq[i].eir));
      chk($sformatf("v%0d_a_valid", i), 64'(a_valid), 64'(tq[i].eav));
      chk($sformatf("v%0d_a_data", i), 64'(a_data), 64'(tq[i].ead));
      chk($sformatf("v%0d_b_valid", i), 64'(b_valid), 64'(tq[i].ebv));
      chk($sformatf("v%0d_b_data", i), 64'(b_data), 64'(tq[i].ebd));
      chk($sformatf("v%0d_cnt_a", i), 64'(cnt_a), 64'(tq[i].eca));
      chk($sformatf("v%0d_cnt_b", i), 64'(cnt_b), 64'(tq[i].ecb));
    end

    // ---------------- counter wrap: 2^CNT_W A transfers ----------------
    in_valid = 1'b0; cnt_clr = 1'b1; rr_mode = 1'b0; in_sel = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    step();
    chk("wrap_clear", 64'(cnt_a), 64'd0);
    cnt_clr = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < CNT_MOD; k++) begin
      in_data = 32'hA000_0000 + 32'(k);
      step();
    end
    chk("wrap_pre", 64'(cnt_a), 64'(CNT_MOD - 1));
    in_valid = 1'b0;
    step();
    chk("wrap_zero", 64'(cnt_a), 64'd0);
    chk("wrap_model", 64'(cnt_a), 64'(m_cnt[0]));

    // ---------------- randomized traffic vs model ----------------
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 1'($urandom_range(0, 1));
      rr_mode  = ($urandom_range(0, 2) == 0);
      cnt_clr  = ($urandom_range(0, 31) == 0);
      a_ready  = ($urandom_range(0, 3) != 0);
      b_ready  = ($urandom_range(0, 2) != 0);
      in_data  = $urandom;
      step();
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
